ov7670_fifo_ctrl: RTL and testbench

//  Responder side of the tester/camfifo handshake. Drives the AL422B frame FIFO on the OV7670

---
 rtl/ov7670_fifo_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ov7670_fifo_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_fifo_ctrl.sv
// AL422B frame-FIFO controller for the OV7670 camera board: captures one frame
// between two VSYNC edges, then rewinds the read pointer and returns bytes on request.
`timescale 1ns/1ps
module ov7670_fifo_ctrl #(
  parameter int unsigned FRAME_BYTES = 614400,
  parameter int unsigned RCLK_HALF   = 2,
  parameter int unsigned RRST_CLKS   = 4,
  parameter int unsigned WRST_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_capture_start,
  input  logic       i_read_start,
  input  logic       i_fifo_rd_byte_str,
  output logic       o_fifo_busy,
  output logic       o_fifo_rrst_done,
  output logic       o_data_ready,
  output logic [7:0] o_data_byte,
  input  logic       i_cam_vsync,
  input  logic [7:0] i_fifo_data,
  output logic       o_fifo_wen,
  output logic       o_fifo_wrst_n,
  output logic       o_fifo_rrst_n,
  output logic       o_fifo_rclk,
  output logic       o_fifo_oe_n
);

  localparam int unsigned CNT_W   = $clog2(FRAME_BYTES + 1);
  localparam int unsigned TMR_MAX = (RCLK_HALF > WRST_CYCLES) ? RCLK_HALF : WRST_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned PLS_W   = (RRST_CLKS > 1) ? $clog2(RRST_CLKS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CAP_WAIT_VS,
    CAP_WRST,
    CAP_WRITE,
    RD_RST,
    RD_WAIT,
    RD_HI,
    RD_LO
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   byte_cnt;
  logic [TMR_W-1:0]   tmr;
  logic [PLS_W-1:0]   pls;
  logic               vs_meta;
  logic               vs_sync;
  logic               vs_prev;
  logic               vs_rise_c;

  // VSYNC comes from the camera clock domain; two flops, then edge detect.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= i_cam_vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign vs_rise_c = vs_sync & ~vs_prev;

  // Sequencer: all FIFO pins and handshake outputs are driven from registers here.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state            <= IDLE;
      byte_cnt         <= '0;
      tmr              <= '0;
      pls              <= '0;
      o_fifo_busy      <= 1'b0;
      o_fifo_rrst_done <= 1'b0;
      o_data_ready     <= 1'b0;
      o_data_byte      <= 8'h00;
      o_fifo_wen       <= 1'b0;
      o_fifo_wrst_n    <= 1'b1;
      o_fifo_rrst_n    <= 1'b1;
      o_fifo_rclk      <= 1'b0;
      o_fifo_oe_n      <= 1'b1;
    end else begin
      o_fifo_oe_n      <= 1'b0;
      o_fifo_rrst_done <= 1'b0;
      o_data_ready     <= 1'b0;

      case (state)
        IDLE: begin
          if (i_capture_start) begin
            state       <= CAP_WAIT_VS;
            o_fifo_busy <= 1'b1;
          end else if (i_read_start) begin
            state         <= RD_RST;
            o_fifo_busy   <= 1'b1;
            o_fifo_rrst_n <= 1'b0;
            o_fifo_rclk   <= 1'b1;
            tmr           <= '0;
            pls           <= '0;
          end
        end

        CAP_WAIT_VS: begin
          if (vs_rise_c) begin
            state         <= CAP_WRST;
            o_fifo_wrst_n <= 1'b0;
            tmr           <= '0;
          end
        end

        CAP_WRST: begin
          if (tmr == TMR_W'(WRST_CYCLES - 1)) begin
            state         <= CAP_WRITE;
            o_fifo_wrst_n <= 1'b1;
            o_fifo_wen    <= 1'b1;
            tmr           <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        CAP_WRITE: begin
          if (vs_rise_c) begin
            state       <= IDLE;
            o_fifo_wen  <= 1'b0;
            o_fifo_busy <= 1'b0;
          end
        end

        // Read-pointer reset needs RCLK toggling while RRST is held low.
        RD_RST: begin
          if (tmr == TMR_W'(RCLK_HALF - 1)) begin
            tmr <= '0;
            if (o_fifo_rclk) begin
              o_fifo_rclk <= 1'b0;
            end else if (pls == PLS_W'(RRST_CLKS - 1)) begin
              state            <= RD_WAIT;
              o_fifo_rrst_n    <= 1'b1;
              o_fifo_rrst_done <= 1'b1;
              byte_cnt         <= '0;
            end else begin
              o_fifo_rclk <= 1'b1;
              pls         <= pls + PLS_W'(1);
            end
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        RD_WAIT: begin
          if (byte_cnt == CNT_W'(FRAME_BYTES)) begin
            state       <= IDLE;
            o_fifo_busy <= 1'b0;
          end else if (i_fifo_rd_byte_str) begin
            state       <= RD_HI;
            o_fifo_rclk <= 1'b1;
            tmr         <= '0;
          end
        end

        // Data is sampled at the end of the high phase, after the FIFO access time.
        RD_HI: begin
          if (tmr == TMR_W'(RCLK_HALF - 1)) begin
            state        <= RD_LO;
            o_fifo_rclk  <= 1'b0;
            o_data_byte  <= i_fifo_data;
            o_data_ready <= 1'b1;
            tmr          <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        RD_LO: begin
          if (tmr == TMR_W'(RCLK_HALF - 1)) begin
            state    <= RD_WAIT;
            byte_cnt <= byte_cnt + CNT_W'(1);
            tmr      <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_fifo_ctrl.sv
// Bench for ov7670_fifo_ctrl: a cycle-indexed expected-waveform model built from
// operation timelines, checked every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_ov7670_fifo_ctrl;

  localparam int FB = 8;
  localparam int RH = 2;
  localparam int RC = 4;
  localparam int WC = 4;
  localparam int MAXC = 1024;
  localparam int INF = 1 << 30;

  localparam int B_BUSY = 15;
  localparam int B_DONE = 14;
  localparam int B_RDY  = 13;
  localparam int B_WEN  = 12;
  localparam int B_WRST = 11;
  localparam int B_RRST = 10;
  localparam int B_RCLK = 9;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_capture_start = 1'b0;
  logic       i_read_start = 1'b0;
  logic       i_fifo_rd_byte_str = 1'b0;
  logic       i_cam_vsync = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       o_fifo_busy, o_fifo_rrst_done, o_data_ready;
  logic [7:0] o_data_byte;
  logic       o_fifo_wen, o_fifo_wrst_n, o_fifo_rrst_n, o_fifo_rclk, o_fifo_oe_n;

  ov7670_fifo_ctrl #(
    .FRAME_BYTES(FB), .RCLK_HALF(RH), .RRST_CLKS(RC), .WRST_CYCLES(WC)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_capture_start(i_capture_start), .i_read_start(i_read_start),
    .i_fifo_rd_byte_str(i_fifo_rd_byte_str),
    .o_fifo_busy(o_fifo_busy), .o_fifo_rrst_done(o_fifo_rrst_done),
    .o_data_ready(o_data_ready), .o_data_byte(o_data_byte),
    .i_cam_vsync(i_cam_vsync), .i_fifo_data(fifo_data),
    .o_fifo_wen(o_fifo_wen), .o_fifo_wrst_n(o_fifo_wrst_n),
    .o_fifo_rrst_n(o_fifo_rrst_n), .o_fifo_rclk(o_fifo_rclk),
    .o_fifo_oe_n(o_fifo_oe_n)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  // AL422B read side: pointer rewinds on RCLK rises while RRST is low.
  int rd_ptr = 0;
  always @(posedge o_fifo_rclk) begin
    #1;
    if (!o_fifo_rrst_n) rd_ptr = 0;
    else begin
      fifo_data = 8'hA0 + 8'(rd_ptr);
      rd_ptr++;
    end
  end

  // ---------------- expected-waveform model ----------------
  logic [15:0] exp_v [MAXC];
  int m_mode = 0;        // 0 idle, 1 capture waiting, 2 capture writing, 3 readout
  int idle_from = 0;
  int cap_from = 0;
  int wen_from = 0;
  int wait_free = 0;
  int rd_count = 0;

  task automatic put(input int b, input int from, input int to, input logic v);
    for (int c = from; c <= to && c < MAXC; c++) exp_v[c][b] = v;
  endtask

  task automatic put_byte(input int from, input logic [7:0] v);
    for (int c = from; c < MAXC; c++) exp_v[c][7:0] = v;
  endtask

  task automatic reset_model(input int from);
    for (int c = from; c < MAXC; c++) exp_v[c] = 16'h0C00;
    m_mode = 0;
    idle_from = from;
    rd_count = 0;
  endtask

  task automatic m_start(input int n, input bit cap, input bit rd);
    if (n < idle_from) return;
    if (cap) begin
      m_mode = 1;
      cap_from = n + 1;
      idle_from = INF;
      put(B_BUSY, n + 1, MAXC - 1, 1'b1);
    end else if (rd) begin
      m_mode = 3;
      idle_from = INF;
      rd_count = 0;
      put(B_BUSY, n + 1, MAXC - 1, 1'b1);
      put(B_RRST, n + 1, n + 2 * RH * RC, 1'b0);
      for (int p = 0; p < RC; p++) put(B_RCLK, n + 1 + 2 * RH * p, n + RH + 2 * RH * p, 1'b1);
      put(B_DONE, n + 2 * RH * RC + 1, n + 2 * RH * RC + 1, 1'b1);
      wait_free = n + 2 * RH * RC + 1;
    end
  endtask

  task automatic m_vsync(input int v);
    int r;
    r = v + 2;
    if (m_mode == 1 && r >= cap_from) begin
      m_mode = 2;
      put(B_WRST, r + 1, r + WC, 1'b0);
      wen_from = r + WC + 1;
      put(B_WEN, wen_from, MAXC - 1, 1'b1);
    end else if (m_mode == 2 && r >= wen_from) begin
      m_mode = 0;
      put(B_WEN, r + 1, MAXC - 1, 1'b0);
      put(B_BUSY, r + 1, MAXC - 1, 1'b0);
      idle_from = r + 1;
    end
  endtask

  task automatic m_strobe(input int s);
    if (m_mode != 3 || s < wait_free || rd_count >= FB) return;
    put(B_RCLK, s + 1, s + RH, 1'b1);
    put(B_RDY, s + RH + 1, s + RH + 1, 1'b1);
    put_byte(s + RH + 1, 8'hA0 + 8'(rd_count));
    rd_count++;
    wait_free = s + 2 * RH + 1;
    if (rd_count == FB) begin
      m_mode = 0;
      put(B_BUSY, s + 2 * RH + 2, MAXC - 1, 1'b0);
      idle_from = s + 2 * RH + 2;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clk) begin
    logic [15:0] act;
    if (chk_en) begin
      if (cyc >= MAXC) begin
        $display("FAIL model_range cyc=%0d exceeds %0d", cyc, MAXC);
        $fatal(1);
      end
      act = {o_fifo_busy, o_fifo_rrst_done, o_data_ready, o_fifo_wen, o_fifo_wrst_n,
             o_fifo_rrst_n, o_fifo_rclk, o_fifo_oe_n, o_data_byte};
      total++;
      if (act !== exp_v[cyc]) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%h want=%h (busy,done,rdy,wen,wrst_n,rrst_n,rclk,oe_n,byte)",
                 cyc, act, exp_v[cyc]);
      end
    end
  end

  // ---------------- activity monitors ----------------
  int wrst_lo_cnt = 0, wen_hi_cnt = 0, rrst_lo_cnt = 0, done_cnt = 0, ready_cnt = 0;
  int rclk_rise_cnt = 0;
  always @(negedge i_clk) begin
    if (!o_fifo_wrst_n) wrst_lo_cnt++;
    if (o_fifo_wen) wen_hi_cnt++;
    if (!o_fifo_rrst_n) rrst_lo_cnt++;
    if (o_fifo_rrst_done) done_cnt++;
    if (o_data_ready) ready_cnt++;
  end
  always @(posedge o_fifo_rclk) rclk_rise_cnt++;

  task automatic clr();
    wrst_lo_cnt = 0; wen_hi_cnt = 0; rrst_lo_cnt = 0;
    done_cnt = 0; ready_cnt = 0; rclk_rise_cnt = 0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic do_start(input bit cap, input bit rd);
    m_start(cyc, cap, rd);
    i_capture_start = cap;
    i_read_start = rd;
    tick();
    i_capture_start = 1'b0;
    i_read_start = 1'b0;
  endtask

  task automatic do_strobe();
    m_strobe(cyc);
    i_fifo_rd_byte_str = 1'b1;
    tick();
    i_fifo_rd_byte_str = 1'b0;
  endtask

  task automatic do_vsync();
    m_vsync(cyc);
    i_cam_vsync = 1'b1;
    run(3);
    i_cam_vsync = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(o_fifo_busy), 0);
    chk({tag, "_rrst_done"}, int'(o_fifo_rrst_done), 0);
    chk({tag, "_data_ready"}, int'(o_data_ready), 0);
    chk({tag, "_data_byte"}, int'(o_data_byte), 0);
    chk({tag, "_wen"}, int'(o_fifo_wen), 0);
    chk({tag, "_wrst_n"}, int'(o_fifo_wrst_n), 1);
    chk({tag, "_rrst_n"}, int'(o_fifo_rrst_n), 1);
    chk({tag, "_rclk"}, int'(o_fifo_rclk), 0);
    chk({tag, "_oe_n"}, int'(o_fifo_oe_n), 1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    reset_model(0);
    repeat (3) @(posedge i_clk);
    #1;
    chk_reset_outputs("reset");
    i_rstn = 1'b1;
    reset_model(cyc + 1);
    tick();
    chk_en = 1'b1;
    chk("oe_n_after_reset", int'(o_fifo_oe_n), 0);

    // Capture; read start and strobes issued mid-capture must be ignored.
    do_start(1'b1, 1'b0);
    run(2);
    clr();
    do_vsync();
    do_start(1'b0, 1'b1);
    do_strobe();
    do_strobe();
    run(7);
    do_vsync();
    run(6);
    chk("cap_wrst_low_cycles", wrst_lo_cnt, 4);
    chk("cap_wen_high_cycles", wen_hi_cnt, 9);
    chk("cap_rclk_rises", rclk_rise_cnt, 0);
    chk("cap_rrst_done_pulses", done_cnt, 0);
    chk("cap_busy_end", int'(o_fifo_busy), 0);

    // Readout of a full frame.
    clr();
    do_start(1'b0, 1'b1);
    run(2 * RH * RC);
    chk("rd_rrst_low_cycles", rrst_lo_cnt, 16);
    chk("rd_rrst_rclk_rises", rclk_rise_cnt, 4);
    chk("rd_rrst_done_now", int'(o_fifo_rrst_done), 1);
    chk("rd_busy", int'(o_fifo_busy), 1);
    clr();
    s = cyc;
    do_strobe();
    run(2);
    chk("rd_first_ready", int'(o_data_ready), 1);
    chk("rd_first_byte", int'(o_data_byte), 'hA0);
    while (cyc < s + 5) tick();
    for (int k = 1; k < FB; k++) begin
      s = cyc;
      do_strobe();
      if (k == 2) do_strobe();
      while (cyc < s + 5 + k % 3) tick();
    end
    run(3);
    do_strobe();
    run(5);
    chk("rd_ready_pulses", ready_cnt, 8);
    chk("rd_rclk_rises", rclk_rise_cnt, 8);
    chk("rd_last_byte", int'(o_data_byte), 'hA7);
    chk("rd_busy_end", int'(o_fifo_busy), 0);

    // Simultaneous starts: capture wins, no read-pointer reset.
    clr();
    do_start(1'b1, 1'b1);
    run(4);
    do_vsync();
    run(10);
    do_vsync();
    run(6);
    chk("both_rrst_low_cycles", rrst_lo_cnt, 0);
    chk("both_rrst_done_pulses", done_cnt, 0);
    chk("both_wen_high_cycles", wen_hi_cnt, 9);

    // Asynchronous reset while RCLK is high, then a fresh readout.
    do_start(1'b0, 1'b1);
    run(2 * RH * RC);
    do_strobe();
    chk("mid_rclk_high", int'(o_fifo_rclk), 1);
    #2;
    chk_en = 1'b0;
    i_rstn = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    tick();
    tick();
    i_rstn = 1'b1;
    reset_model(cyc + 1);
    tick();
    chk_en = 1'b1;
    do_start(1'b0, 1'b1);
    run(2 * RH * RC);
    do_strobe();
    run(2);
    chk("restart_ready", int'(o_data_ready), 1);
    chk("restart_byte", int'(o_data_byte), 'hA0);
    run(3);
    chk("restart_busy", int'(o_fifo_busy), 1);
    run(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
